// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, access owner and
// the fixed fetch access size.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FE  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_e;

  // Instruction fetches are always 32-bit word reads.
  localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, MEM-stage and memory-side signals around the shared
// data-memory port; the arbiter connects through the slave modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic              FE_REQ;
  logic [ADDR_W-1:0] FE_ADDR;
  logic              FE_ACK;
  logic [31:0]       FE_RDATA;
  logic              FE_STALL;

  logic              MEM_REQ;
  logic              MEM_R_W;
  logic [2:0]        MEM_SIZE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic              MEM_ACK;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_STALL;

  logic              M_REQ;
  logic              M_R_W;
  logic [2:0]        M_SIZE;
  logic [ADDR_W-1:0] M_ADDR;
  logic [DATA_W-1:0] M_WDATA;
  logic              M_READY;
  logic [DATA_W-1:0] M_RDATA;

  modport slave (
    input  FE_REQ, FE_ADDR,
    input  MEM_REQ, MEM_R_W, MEM_SIZE, MEM_ADDR, MEM_WDATA,
    input  M_READY, M_RDATA,
    output FE_ACK, FE_RDATA, FE_STALL,
    output MEM_ACK, MEM_RDATA, MEM_STALL,
    output M_REQ, M_R_W, M_SIZE, M_ADDR, M_WDATA
  );

  modport master (
    output FE_REQ, FE_ADDR,
    output MEM_REQ, MEM_R_W, MEM_SIZE, MEM_ADDR, MEM_WDATA,
    output M_READY, M_RDATA,
    input  FE_ACK, FE_RDATA, FE_STALL,
    input  MEM_ACK, MEM_RDATA, MEM_STALL,
    input  M_REQ, M_R_W, M_SIZE, M_ADDR, M_WDATA
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch and the MEM stage, one
// access at a time (IDLE/BUSY/RESP). Define MEM_ARB_STARVE_GUARD_EN to force a
// fetch grant after STARVE_LIMIT consecutive MEM grants with fetch waiting.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_RESP = RESP;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
  end

  logic [1:0]        state_q,     state_d;
  arb_owner_e        owner_q,     owner_d;
  logic              m_req_q,     m_req_d;
  logic              m_r_w_q,     m_r_w_d;
  logic [2:0]        m_size_q,    m_size_d;
  logic [ADDR_W-1:0] m_addr_q,    m_addr_d;
  logic [DATA_W-1:0] m_wdata_q,   m_wdata_d;
  logic [31:0]       fe_rdata_q,  fe_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              fe_ack_q,    fe_ack_d;
  logic              mem_ack_q,   mem_ack_d;

  logic grant;
  logic grant_fe;
  logic fe_forced;

  assign grant    = (state_q == S_IDLE) && (bus.FE_REQ || bus.MEM_REQ);
  // MEM wins unless it is idle or fetch has been starved long enough.
  assign grant_fe = fe_forced || !bus.MEM_REQ;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign fe_forced = bus.FE_REQ && (starve_q >= CNT_MAX);

  always_comb begin
    starve_d = starve_q;
    if (!bus.FE_REQ) begin
      starve_d = '0;
    end else if (grant && grant_fe) begin
      starve_d = '0;
    end else if (grant && (starve_q < CNT_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign fe_forced = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    m_req_d     = m_req_q;
    m_r_w_d     = m_r_w_q;
    m_size_d    = m_size_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    fe_rdata_d  = fe_rdata_q;
    mem_rdata_d = mem_rdata_q;
    fe_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_BUSY;
          m_req_d = 1'b1;
          if (grant_fe) begin
            owner_d   = OWN_FE;
            m_r_w_d   = 1'b0;
            m_size_d  = SIZE_WORD;
            m_addr_d  = bus.FE_ADDR;
            m_wdata_d = '0;
          end else begin
            owner_d   = OWN_MEM;
            m_r_w_d   = bus.MEM_R_W;
            m_size_d  = bus.MEM_SIZE;
            m_addr_d  = bus.MEM_ADDR;
            m_wdata_d = bus.MEM_WDATA;
          end
        end
      end

      S_BUSY: begin
        // No timeout: the memory file always completes an access it was given.
        if (bus.M_READY) begin
          state_d = S_RESP;
          m_req_d = 1'b0;
          if (owner_q == OWN_FE) begin
            fe_rdata_d = bus.M_RDATA[31:0];
            fe_ack_d   = 1'b1;
          end else begin
            if (!m_r_w_q) begin
              mem_rdata_d = bus.M_RDATA;
            end
            mem_ack_d = 1'b1;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_FE;
      m_req_q     <= 1'b0;
      m_r_w_q     <= 1'b0;
      m_size_q    <= '0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      fe_rdata_q  <= '0;
      mem_rdata_q <= '0;
      fe_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      m_req_q     <= m_req_d;
      m_r_w_q     <= m_r_w_d;
      m_size_q    <= m_size_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      fe_rdata_q  <= fe_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      fe_ack_q    <= fe_ack_d;
      mem_ack_q   <= mem_ack_d;
    end
  end

  assign bus.M_REQ     = m_req_q;
  assign bus.M_R_W     = m_r_w_q;
  assign bus.M_SIZE    = m_size_q;
  assign bus.M_ADDR    = m_addr_q;
  assign bus.M_WDATA   = m_wdata_q;
  assign bus.FE_ACK    = fe_ack_q;
  assign bus.FE_RDATA  = fe_rdata_q;
  assign bus.MEM_ACK   = mem_ack_q;
  assign bus.MEM_RDATA = mem_rdata_q;

  // Stalls depend only on the request level and the registered ACKs.
  assign bus.FE_STALL  = bus.FE_REQ  && !fe_ack_q;
  assign bus.MEM_STALL = bus.MEM_REQ && !mem_ack_q;

endmodule
